// File: rtl/xc_aesmix_ctrl_pkg.sv
// Shared constants and types for the AES MixColumns sequencing controller.
// FSM encodings are plain localparams so legacy code can compare against them directly.
package xc_aesmix_ctrl_pkg;

   localparam int COLW = 2;
   localparam int STW  = 2;

   localparam logic [STW-1:0] IDLE = 2'd0;
   localparam logic [STW-1:0] RUN  = 2'd1;
   localparam logic [STW-1:0] DONE = 2'd2;

   typedef logic [31:0]       col_t;
   typedef logic [3:0][31:0]  state_buf_t;

endpackage

// File: rtl/xc_aesmix_ctrl_if.sv
// Request, result and datapath-side signals of the MixColumns controller.
// slave is the controller's view; master is the view of the parent/datapath driving it.
interface xc_aesmix_ctrl_if;

   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_enc;
   logic         flush;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         mix_valid;
   logic [31:0]  mix_rs1;
   logic [31:0]  mix_rs2;
   logic [31:0]  mix_enc;
   logic         mix_ready;
   logic [31:0]  mix_result;

   modport slave (
      input  in_valid, in_state, in_enc, flush, out_ready, mix_ready, mix_result,
      output in_ready, out_valid, out_state, mix_valid, mix_rs1, mix_rs2, mix_enc
   );

   modport master (
      output in_valid, in_state, in_enc, flush, out_ready, mix_ready, mix_result,
      input  in_ready, out_valid, out_state, mix_valid, mix_rs1, mix_rs2, mix_enc
   );

endinterface

// File: rtl/xc_aesmix_ctrl.sv
// Sequences one 128-bit AES state through a shared single-column MixColumns datapath.
// Latency NCOLS+1 cycles from accept with mix_ready=1; stalls hold all outputs, result held until out_ready.
module xc_aesmix_ctrl
   import xc_aesmix_ctrl_pkg::*;
#(
   parameter int NCOLS     = 4,
   parameter bit ZERO_IDLE = 1'b1
) (
   input logic             clock,
   input logic             reset,
   xc_aesmix_ctrl_if.slave bus
);

   localparam logic [COLW-1:0] LAST_COL = COLW'(NCOLS - 1);

   logic [STW-1:0]  state_q, state_d;
   logic [COLW-1:0] col_q, col_d;
   state_buf_t      buf_q, buf_d;
   logic            enc_q, enc_d;
   col_t            hold_q, hold_d;
   col_t            mix_word;
   logic            run;

   assign run = (state_q == RUN);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      buf_d   = buf_q;
      enc_d   = enc_q;
      hold_d  = run ? buf_q[col_q] : hold_q;

      // flush wins over every handshake, including a mix_ready in the same cycle
      if (bus.flush) begin
         state_d = IDLE;
         col_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  buf_d   = bus.in_state;
                  enc_d   = bus.in_enc;
                  col_d   = '0;
                  state_d = RUN;
               end
            end
            RUN: begin
               if (bus.mix_ready) begin
                  buf_d[col_q] = bus.mix_result;
                  if (col_q == LAST_COL) begin
                     state_d = DONE;
                  end else begin
                     col_d = col_q + COLW'(1);
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         col_q   <= '0;
         buf_q   <= '0;
         enc_q   <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         col_q   <= col_d;
         buf_q   <= buf_d;
         enc_q   <= enc_d;
         hold_q  <= hold_d;
      end
   end

   // hold_q keeps the last issued word for builds without operand isolation
   assign mix_word = run ? buf_q[col_q] : (ZERO_IDLE ? '0 : hold_q);

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_state = buf_q;
   assign bus.mix_valid = run;
   assign bus.mix_rs1   = mix_word;
   assign bus.mix_rs2   = mix_word;
   assign bus.mix_enc   = {31'b0, enc_q};

endmodule
